stream_layer_acc: RTL
=====================

// Module: stream_layer_acc
// PURPOSE
// Parametrised stochastic-bitstream dense layer with run control and result accumulation.
// NEURON_COUNT neurons each generate per-cycle weight bitstreams, multiply them with layer_input and scale-add.
// Each neuron output bit is counted over a STREAM_LEN-cycle window.
// Per-neuron ones-counts are returned through a valid/ready handshake; sits between stream sources and the next layer or readout.
// PARAMETERS
// INPUT_SIZE    2    input bitstreams per neuron
// NEURON_COUNT  2    neurons in layer
// WEIGHT_WIDTH  8    weight/bias/LFSR width (probability = value/(2^W-1))
// STREAM_LEN    256  RUN cycles per evaluation window
// SEED          0    base LFSR seed; neuron i seed = SEED + i*NEURON_COUNT*35, truncated to W bits, 0 replaced by 1
// PORTS
// clk           in   1                      clock, rising edge
// n_rst         in   1                      asynchronous active-low reset
// start         in   1                      request run; accepted only in IDLE
// weights       in   [N][I][W]              per-neuron per-input weight, sampled on start acceptance
// bias          in   [N][W]                 per-neuron bias, sampled on start acceptance
// layer_input   in   [INPUT_SIZE]           live input bitstreams, used every RUN cycle
// busy          out  1                      1 in RUN or DONE
// layer_output  out  [NEURON_COUNT]         registered neuron bitstream bits
// count_out     out  [N][CW]                ones-count per neuron, CW = $clog2(STREAM_LEN+1)
// result_valid  out  1                      counts valid (DONE state)
// result_ready  in   1                      consumer accepts counts
// BEHAVIOUR
// - Reset (async, n_rst=0): state IDLE; all outputs 0; counters, sel and weight/bias regs 0; LFSRs = seeds.
// - FSM IDLE -> RUN on start=1: latch weights/bias, reload LFSRs with seeds, clear counts, sel=0, run counter=0.
// - RUN: one stream cycle per clk. After the STREAM_LEN-th RUN cycle -> DONE.
// - DONE: result_valid=1, count_out held stable. result_valid & result_ready -> IDLE next cycle (ready may be high on first DONE cycle).
// - start in RUN/DONE is ignored; no queueing.
// - Per neuron i, each RUN cycle:
//   - LFSR: W-bit maximal-length Fibonacci LFSR, never 0.
//   - r_j = LFSR rotated left by j; w_bit_j = (r_j <= weights[i][j]).
//   - b_bit = (LFSR <= bias[i]). Weight 0 -> bit always 0; weight 2^W-1 -> bit always 1.
//   - term_j = layer_input[j] & w_bit_j; sel in [0..INPUT_SIZE], wraps INPUT_SIZE->0 every RUN cycle.
//   - Neuron bit = term_sel, or b_bit when sel==INPUT_SIZE; sel is shared by all neurons.
//   - layer_output[i] registers the neuron bit; count_out[i] += neuron bit in the same cycle.
//   - LFSR steps after use.
// - Latency: start accepted at edge 0; first layer_output bit visible after edge 1; result_valid after edge STREAM_LEN+1.
// - layer_output holds its last value outside RUN and returns to 0 on next start acceptance.
// - Counts cannot overflow (max = STREAM_LEN); no saturation logic.
// - Reset mid-RUN/DONE aborts the run; the next run is bit-identical to a fresh run with the same stimulus.
// CONFIGURATION
// - LAYER_BIPOLAR_EN defined:
//   - term_j = ~(layer_input[j] ^ w_bit_j), bipolar XNOR multiply.
//   - Bias term unchanged.
// - LAYER_BIPOLAR_EN undefined: unipolar AND multiply as above.
// - Ports, timing and FSM identical in both modes.
// TESTING (INPUT_SIZE=2, NEURON_COUNT=2, W=8, STREAM_LEN=255 unless noted)
// 1. Assert n_rst=0 mid-run -> all outputs 0 at once; state IDLE.
//    Rerun with the same stimulus -> count_out equal to the uninterrupted run.
// 2. Weights=0, bias=0, inputs=1, start -> result_valid after 256 edges; all count_out=0.
// 3. Weights=255, bias=255, inputs=1 -> all count_out=255; layer_output constant 1 during RUN.
// 4. Weights=255, bias=0, inputs=1 -> count_out=170 (sel==2 on 85 cycles).
// 5. Hold result_ready=0 for 10 cycles in DONE, pulse start -> counts stable; start ignored.
//    Assert ready -> IDLE next cycle; busy=0.
// 6. LAYER_BIPOLAR_EN, weights=0, bias=0, inputs=0 -> count_out=170 per neuron.

Source files
------------

// File: rtl/stream_layer_acc.sv
// Stochastic-bitstream dense layer: per-neuron LFSR weight streams, shared input/bias select, and
// per-neuron ones-count over a STREAM_LEN window. Define LAYER_BIPOLAR_EN for XNOR (bipolar) multiply.
module stream_layer_acc #(
    parameter int unsigned INPUT_SIZE   = 2,
    parameter int unsigned NEURON_COUNT = 2,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned STREAM_LEN   = 256,
    parameter int unsigned SEED         = 0,
    localparam int unsigned CW          = $clog2(STREAM_LEN + 1)
) (
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        start,
    input  logic [NEURON_COUNT*INPUT_SIZE*WEIGHT_WIDTH-1:0] weights,
    input  logic [NEURON_COUNT*WEIGHT_WIDTH-1:0]        bias,
    input  logic [INPUT_SIZE-1:0]                       layer_input,
    output logic                                        busy,
    output logic [NEURON_COUNT-1:0]                     layer_output,
    output logic [NEURON_COUNT*CW-1:0]                  count_out,
    output logic                                        result_valid,
    input  logic                                        result_ready
);

    localparam int unsigned W  = WEIGHT_WIDTH;
    localparam int unsigned SW = $clog2(INPUT_SIZE + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Maximal-length tap masks for widths 3..16.
    function automatic logic [31:0] tap_mask(input int unsigned width);
        case (width)
            3:       tap_mask = 32'h0000_0006;
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            9:       tap_mask = 32'h0000_0110;
            10:      tap_mask = 32'h0000_0240;
            11:      tap_mask = 32'h0000_0500;
            12:      tap_mask = 32'h0000_0829;
            13:      tap_mask = 32'h0000_100D;
            14:      tap_mask = 32'h0000_2015;
            15:      tap_mask = 32'h0000_6000;
            16:      tap_mask = 32'h0000_D008;
            default: tap_mask = 32'h0000_00B8;
        endcase
    endfunction

    localparam logic [31:0]  TapsAll = tap_mask(W);
    localparam logic [W-1:0] Taps    = TapsAll[W-1:0];

    function automatic logic [NEURON_COUNT*W-1:0] seed_init();
        logic [31:0]  s;
        logic [W-1:0] v;
        seed_init = '0;
        for (int unsigned i = 0; i < NEURON_COUNT; i++) begin
            s = SEED + i * NEURON_COUNT * 35;
            v = s[W-1:0];
            if (v == '0) v = W'(1);
            seed_init[i*W +: W] = v;
        end
    endfunction

    localparam logic [NEURON_COUNT*W-1:0] SeedInit = seed_init();

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        lfsr_step = {v[W-2:0], ^(v & Taps)};
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned j);
        logic [2*W-1:0] t;
        t    = {v, v} << (j % W);
        rotl = t[2*W-1:W];
    endfunction

    logic [1:0]                           state_q, state_d;
    logic [NEURON_COUNT*INPUT_SIZE*W-1:0] w_q, w_d;
    logic [NEURON_COUNT*W-1:0]            b_q, b_d;
    logic [NEURON_COUNT*W-1:0]            lfsr_q, lfsr_d;
    logic [SW-1:0]                        sel_q, sel_d;
    logic [CW-1:0]                        run_q, run_d;
    logic [NEURON_COUNT*CW-1:0]           cnt_q, cnt_d;
    logic [NEURON_COUNT-1:0]              out_q, out_d;

    logic [NEURON_COUNT-1:0]              nbit;
    logic [NEURON_COUNT*W-1:0]            lfsr_nxt;

    for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_neuron
        logic [W-1:0]          lfsr;
        logic [INPUT_SIZE:0]   term;

        assign lfsr = lfsr_q[gi*W +: W];

        // term[INPUT_SIZE] is the bias stream so sel indexes the whole set directly.
        always_comb begin
            term = '0;
            for (int unsigned j = 0; j < INPUT_SIZE; j++) begin
`ifdef LAYER_BIPOLAR_EN
                term[j] = ~(layer_input[j] ^ (rotl(lfsr, j) <= w_q[(gi*INPUT_SIZE+j)*W +: W]));
`else
                term[j] = layer_input[j] & (rotl(lfsr, j) <= w_q[(gi*INPUT_SIZE+j)*W +: W]);
`endif
            end
            term[INPUT_SIZE] = (lfsr <= b_q[gi*W +: W]);
        end

        assign nbit[gi]              = term[sel_q];
        assign lfsr_nxt[gi*W +: W]   = lfsr_step(lfsr);
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        b_d     = b_q;
        lfsr_d  = lfsr_q;
        sel_d   = sel_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    w_d     = weights;
                    b_d     = bias;
                    lfsr_d  = SeedInit;
                    sel_d   = '0;
                    run_d   = '0;
                    cnt_d   = '0;
                    out_d   = '0;
                end
            end
            StRun: begin
                // Last stream bit lands at edge STREAM_LEN; DONE follows one edge later.
                if (run_q != CW'(STREAM_LEN)) begin
                    out_d  = nbit;
                    lfsr_d = lfsr_nxt;
                    sel_d  = (sel_q == SW'(INPUT_SIZE)) ? '0 : sel_q + SW'(1);
                    run_d  = run_q + CW'(1);
                    for (int unsigned i = 0; i < NEURON_COUNT; i++) begin
                        cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CW'(nbit[i]);
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            w_q     <= '0;
            b_q     <= '0;
            lfsr_q  <= SeedInit;
            sel_q   <= '0;
            run_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            b_q     <= b_d;
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign layer_output = out_q;
    assign count_out    = cnt_q;

endmodule
